// File: rtl/lfsr_byte_scrambler.sv
// rtl/lfsr_byte_scrambler.sv - byte scrambler sequencing an external Galois LFSR, 8 steps per byte
// Optional automatic reseed every RESEED_BYTES output bytes when SCRAMBLER_RESEED_EN is defined.
module lfsr_byte_scrambler #(
  parameter int N            = 32,
  parameter int RESEED_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] seed_i,
  input  logic         seed_load,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lfsr_en,
  output logic         lfsr_ld,
  output logic [N-1:0] lfsr_seed,
  input  logic         lfsr_k,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, OUT} state_t;

  state_t       state;
  logic [N-1:0] seed_q;
  logic         pend;
  logic [7:0]   ks_q;
  logic [7:0]   din_q;
  logic [2:0]   bit_cnt;
  logic [7:0]   out_q;
  logic         auto_reseed;

`ifdef SCRAMBLER_RESEED_EN
  logic [15:0] byte_cnt;

  assign auto_reseed = (state == OUT) && out_ready &&
                       (byte_cnt + 16'd1 == 16'(RESEED_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (state == OUT && out_ready) begin
      byte_cnt <= auto_reseed ? 16'd0 : byte_cnt + 16'd1;
    end
  end
`else
  assign auto_reseed = 1'b0;
`endif

  // Every output is a pure decode of registered state, so in_ready never sees out_ready.
  assign in_ready  = (state == IDLE) && !pend;
  assign lfsr_en   = (state == SHIFT);
  assign lfsr_ld   = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_data  = out_q;
  assign lfsr_seed = seed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      seed_q  <= '1;
      pend    <= 1'b0;
      ks_q    <= '0;
      din_q   <= '0;
      bit_cnt <= '0;
      out_q   <= '0;
    end else begin
      // A new external seed outranks the clear in LOAD; the last seed written wins.
      if (seed_load) begin
        seed_q <= seed_i;
        pend   <= 1'b1;
      end else if (auto_reseed) begin
        pend <= 1'b1;
      end else if (state == LOAD) begin
        pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pend) begin
            state <= LOAD;
          end else if (in_valid) begin
            din_q   <= in_data;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        SHIFT: begin
          ks_q    <= {ks_q[6:0], lfsr_k};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            out_q <= din_q ^ {ks_q[6:0], lfsr_k};
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_byte_scrambler.sv
// tb/tb_lfsr_byte_scrambler.sv - scoreboard bench for lfsr_byte_scrambler with a Galois LFSR model
module tb_lfsr_byte_scrambler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seed_i = '0;
  logic        seed_load = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        lfsr_en;
  logic        lfsr_ld;
  logic [31:0] lfsr_seed;
  logic        lfsr_k;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_ld_cyc = 0;
  int ld_cnt = 0;
  int en_cnt = 0;
  logic prev_ov = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  lfsr_byte_scrambler #(.N(32), .RESEED_BYTES(2)) dut (
    .clk(clk), .rst(rst), .seed_i(seed_i), .seed_load(seed_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .lfsr_en(lfsr_en), .lfsr_ld(lfsr_ld), .lfsr_seed(lfsr_seed),
    .lfsr_k(lfsr_k), .busy(busy)
  );

  // Galois LFSR, taps 0x04C11DB7, synchronous reset to all ones
  logic [31:0] lfsr_st;
  always_ff @(posedge clk) begin
    if (rst) lfsr_st <= '1;
    else if (lfsr_ld) lfsr_st <= lfsr_seed;
    else if (lfsr_en) lfsr_st <= {lfsr_st[30:0], 1'b0} ^ (lfsr_st[31] ? 32'h04C11DB7 : 32'h0);
  end
  assign lfsr_k = lfsr_st[31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      en_cnt = 0;
      prev_ov = 1'b0;
    end else begin
      if (lfsr_en) en_cnt++;
      if (lfsr_ld) begin
        ld_cnt++;
        last_ld_cyc = cyc;
      end
      if (lfsr_en || lfsr_ld) check("en_ld_overlap", 32'(lfsr_en & lfsr_ld), 32'd0);
      if (out_valid && !prev_ov) check("accept_to_valid", 32'(cyc - acc_cyc), 32'd9);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          if (!out_ready) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_lfsr_en", 32'(lfsr_en), 32'd0);
          end else begin
            check("en_pulses", 32'(en_cnt), 32'd8);
            en_cnt = 0;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] e);
    bit done = 1'b0;
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    check("accept_timeout", 32'(done), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int p;
    int ld0;
    bit seen;

    do_reset();
    @(negedge clk);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_lfsr_en", 32'(lfsr_en), 32'd0);
    check("rst_lfsr_ld", 32'(lfsr_ld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lfsr_seed", lfsr_seed, 32'hFFFFFFFF);

    // 1: zero byte exposes raw keystream
    send(8'h00, 8'hFC);
    drain();

    // 2: 0xFF with a 5-cycle downstream stall
    do_reset();
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'hFF, 8'h03);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("t2_valid_seen", 32'(seen), 32'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // 3: reseed during SHIFT takes effect only on the next byte
    do_reset();
    send(8'h00, 8'hFC);
    repeat (3) @(posedge clk);
    #1 seed_i = 32'hFFFFFFFF; seed_load = 1'b1;
    @(posedge clk); #1 seed_load = 1'b0;
    ld0 = ld_cnt;
    send(8'h00, 8'hFC);
    check("t3_ld_count", 32'(ld_cnt - ld0), 32'd1);
    check("t3_ld_then_accept", 32'(acc_cyc - last_ld_cyc), 32'd1);
    drain();

    // 4: back-to-back bytes, second keystream byte 0x4F
    do_reset();
    send(8'h00, 8'hFC);
    p = acc_cyc;
    send(8'h00, 8'h4F);
    check("t4_spacing", 32'(acc_cyc - p), 32'd10);
    drain();

    // 5: asynchronous reset in the 4th SHIFT cycle
    do_reset();
    @(posedge clk); #1 in_data = 8'h5A; in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = in_ready;
    end
    check("t5_accept", 32'(seen), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_busy_before", 32'(busy), 32'd1);
    check("t5_en_before", 32'(lfsr_en), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_lfsr_en", 32'(lfsr_en), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(8'h00, 8'hFC);
    drain();

`ifdef SCRAMBLER_RESEED_EN
    // 6: automatic reseed every 2 bytes
    do_reset();
    ld0 = ld_cnt;
    send(8'h00, 8'hFC);
    send(8'h00, 8'h4F);
    send(8'h00, 8'hFC);
    send(8'h00, 8'h4F);
    drain();
    repeat (3) @(posedge clk);
    check("t6_ld_count", 32'(ld_cnt - ld0), 32'd2);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
